network_can_onchip_mem_ctrl: RTL and testbench

NETWORK_CAN_ONCHIP_MEM_CTRL -- requirements
Module: network_can_onchip_mem_ctrl

---
 rtl/network_can_onchip_mem_ctrl.sv | 126 ++++++++++++
 tb/tb_network_can_onchip_mem_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/network_can_onchip_mem_ctrl.sv
// Single-port on-chip RAM behind an Avalon-MM slave: byte-lane writes, fixed-latency reads,
// a global clock-enable stall and an optional zero-fill sweep after reset.
module network_can_onchip_mem_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 11,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reset_req,
  input  logic                    clken,
  input  logic                    chipselect,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic                    read,
  input  logic                    write,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  output logic                    waitrequest,
  output logic                    init_done
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NBYTES = DATA_WIDTH / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;
  localparam logic [0:0] ST_INIT  = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

  logic [READ_LATENCY-1:0]                 vld_q, vld_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] dat_q, dat_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  en;
  logic                  clr_we;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] wr_merged;

  // A dropped clock enable or a pending reset request freezes every register and the array.
  assign en          = clken & ~reset_req;
  assign waitrequest = (state_q == ST_CLEAR) | ~en;
  assign init_done   = (state_q == ST_READY);

  assign clr_we = en & (state_q == ST_CLEAR);
  assign wr_acc = chipselect & write & ~waitrequest;
  assign rd_acc = chipselect & read & ~write & ~waitrequest;

  assign mem_rdata = mem[address];

  always_comb begin
    wr_merged = mem_rdata;
    for (int b = 0; b < NBYTES; b++) begin
      if (byteenable[b]) begin
        wr_merged[8*b +: 8] = writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    mem_we    = clr_we | wr_acc;
    mem_waddr = clr_we ? clr_addr_q : address;
    mem_wdata = clr_we ? '0 : wr_merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    if (clr_we) begin
      clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
      if (clr_addr_q == {ADDR_WIDTH{1'b1}}) begin
        state_d = ST_READY;
      end
    end
  end

  // Stage 0 captures the array on acceptance; later stages only shift while enabled.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (en) begin
      vld_d[0] = rd_acc;
      if (rd_acc) begin
        dat_d[0] = mem_rdata;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_INIT;
      clr_addr_q <= '0;
      vld_q      <= '0;
      dat_q      <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      vld_q      <= vld_d;
      dat_q      <= dat_d;
    end
  end

  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign readdata      = dat_q[READ_LATENCY-1];

endmodule

// File: tb/tb_network_can_onchip_mem_ctrl.sv
// Bench for network_can_onchip_mem_ctrl: latency-1 and latency-2 instances share stimulus and
// are checked against a word-array model with a queue of pending read results per instance.
module tb_network_can_onchip_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        reset_req;
  logic        clken;
  logic        chipselect;
  logic [10:0] address;
  logic [1:0]  byteenable;
  logic        read;
  logic        write;
  logic [15:0] writedata;

  logic [15:0] rdata1, rdata2;
  logic        rvld1, rvld2;
  logic        wreq1, wreq2;
  logic        idone1, idone2;

  always #5 clk = ~clk;

  network_can_onchip_mem_ctrl u1 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .readdata(rdata1), .readdatavalid(rvld1), .waitrequest(wreq1), .init_done(idone1)
  );

  network_can_onchip_mem_ctrl #(.READ_LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
    .chipselect(chipselect), .address(address), .byteenable(byteenable),
    .read(read), .write(write), .writedata(writedata),
    .readdata(rdata2), .readdatavalid(rvld2), .waitrequest(wreq2), .init_done(idone2)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } rd_t;

  logic [15:0] mem_m [2048];
  rd_t         q1[$];
  rd_t         q2[$];
  int          en_cnt;
  logic        ev1, ev2;
  logic [15:0] ed1, ed2;
  int          n_cmp;
  int          n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2048; i++) mem_m[i] = 16'h0000;
    q1.delete();
    q2.delete();
    ev1 = 1'b0;
    ev2 = 1'b0;
    ed1 = 16'h0000;
    ed2 = 16'h0000;
  endtask

  // Called at a negedge; drives one cycle, checks waitrequest, then all read outputs after the edge.
  task automatic cyc(input logic cs, input logic rd, input logic wr, input logic [10:0] a,
                     input logic [1:0] be, input logic [15:0] wd, input logic ck, input logic rr);
    logic en;
    rd_t  e;
    chipselect = cs; read = rd; write = wr; address = a;
    byteenable = be; writedata = wd; clken = ck; reset_req = rr;
    en = ck & ~rr;
    #1;
    chk("waitrequest_l1", wreq1, !en);
    chk("waitrequest_l2", wreq2, !en);
    @(posedge clk);
    if (en) begin
      en_cnt++;
      if (cs && wr) begin
        for (int b = 0; b < 2; b++)
          if (be[b]) mem_m[a][8*b +: 8] = wd[8*b +: 8];
      end else if (cs && rd) begin
        e.data = mem_m[a];
        e.due  = en_cnt;
        q1.push_back(e);
        e.due  = en_cnt + 1;
        q2.push_back(e);
      end
      ev1 = 1'b0;
      ev2 = 1'b0;
      if (q1.size() > 0 && q1[0].due == en_cnt) begin
        ev1 = 1'b1; ed1 = q1[0].data; void'(q1.pop_front());
      end
      if (q2.size() > 0 && q2[0].due == en_cnt) begin
        ev2 = 1'b1; ed2 = q2[0].data; void'(q2.pop_front());
      end
    end
    #1;
    chk("rdvalid_l1", rvld1, ev1);
    chk("rdvalid_l2", rvld2, ev2);
    if (ev1) chk("rdata_l1", rdata1, ed1);
    if (ev2) chk("rdata_l2", rdata2, ed2);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 11'h000, 2'b00, 16'h0000, 1'b1, 1'b0);
  endtask

  // Called at the negedge where reset was released; counts edges until init_done rises.
  task automatic wait_clear(input string tag);
    int cnt;
    int bad;
    cnt = 0;
    bad = 0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; clken = 1'b1; reset_req = 1'b0;
    while (idone1 !== 1'b1 && cnt < 3000) begin
      @(posedge clk);
      #1;
      cnt++;
      if (rvld1 !== 1'b0 || rvld2 !== 1'b0) bad++;
      if (idone1 !== 1'b1 && (wreq1 !== 1'b1 || wreq2 !== 1'b1)) bad++;
    end
    chk({tag, "_cycles"}, cnt, 2048);
    chk({tag, "_glitches"}, bad, 0);
    chk({tag, "_init_done_l2"}, idone2, 1'b1);
    chk({tag, "_waitreq_after"}, wreq1, 1'b0);
    @(negedge clk);
    model_reset();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; en_cnt = 0;
    model_reset();
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    chipselect = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; byteenable = '0; writedata = '0;

    repeat (3) @(negedge clk);
    chk("rst_rdvalid_l1", rvld1, 1'b0);
    chk("rst_rdvalid_l2", rvld2, 1'b0);
    chk("rst_rdata_l1", rdata1, 16'h0000);
    chk("rst_rdata_l2", rdata2, 16'h0000);
    chk("rst_init_done_l1", idone1, 1'b0);
    chk("rst_init_done_l2", idone2, 1'b0);
    chk("rst_waitreq_l1", wreq1, 1'b1);

    // Abort the sweep part-way through, then require a full-length restart.
    reset = 1'b0;
    repeat (500) @(posedge clk);
    @(negedge clk);
    chk("midclear_init_done", idone1, 1'b0);
    chk("midclear_waitreq", wreq1, 1'b1);
    reset = 1'b1;
    #1;
    chk("midclear_rst_init_done", idone1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("clear_restart");

    cyc(1'b1, 1'b1, 1'b0, 11'h7FF, 2'b11, 16'h0000, 1'b1, 1'b0);
    chk("read_7ff_zero", rdata1, 16'h0000);
    idle();

    cyc(1'b1, 1'b0, 1'b1, 11'h010, 2'b11, 16'hABCD, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 11'h010, 2'b01, 16'h0012, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 11'h010, 2'b00, 16'h0000, 1'b1, 1'b0);
    chk("byte_lane_l1", rdata1, 16'hAB12);
    idle();
    chk("byte_lane_l2", rdata2, 16'hAB12);

    cyc(1'b1, 1'b1, 1'b1, 11'h020, 2'b11, 16'h5555, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 11'h020, 2'b00, 16'h0000, 1'b1, 1'b0);
    chk("rw_collision_readback", rdata1, 16'h5555);
    idle();

    for (int i = 1; i <= 3; i++)
      cyc(1'b1, 1'b0, 1'b1, 11'(i), 2'b11, 16'(16'h1110 + i), 1'b1, 1'b0);
    for (int i = 1; i <= 3; i++)
      cyc(1'b1, 1'b1, 1'b0, 11'(i), 2'b00, 16'h0000, 1'b1, 1'b0);
    idle();
    idle();

    // Stall after an accepted read, once with clken and once with reset_req.
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 1'b1, 1'b0, 11'h010, 2'b00, 16'h0000, 1'b1, 1'b0);
      repeat (3) cyc(1'b1, 1'b1, 1'b0, 11'h020, 2'b00, 16'h0000, (k == 1), (k == 1));
      idle();
      chk("stall_delayed_strobe_l2", rvld2, 1'b1);
      idle();
    end

    // Reset with a read still in flight in the latency-2 instance.
    cyc(1'b1, 1'b1, 1'b0, 11'h010, 2'b00, 16'h0000, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_inflight_rdvalid_l1", rvld1, 1'b0);
    chk("rst_inflight_rdvalid_l2", rvld2, 1'b0);
    chk("rst_inflight_rdata_l1", rdata1, 16'h0000);
    chk("rst_inflight_init_done", idone1, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    wait_clear("clear_after_read");

    for (int n = 0; n < 3000; n++) begin
      logic [10:0] a;
      logic        ck, rr;
      a  = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 15));
      ck = ($urandom_range(0, 99) < 85);
      rr = ($urandom_range(0, 99) < 10);
      cyc(($urandom_range(0, 99) < 80), 1'($urandom), 1'($urandom), a,
          2'($urandom), 16'($urandom), ck, rr);
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
